// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream demux: default widths, FSM encoding
// and the destination routing rule.
package axi_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } demux_state_t;

  // Destination for an incoming beat: sampled from select only on a packet's first beat.
  function automatic logic route_dest(demux_state_t st, logic sel, logic locked_dest);
    return (st == IDLE) ? sel : locked_dest;
  endfunction

endpackage

// File: rtl/axi_stream_demux_if.sv
// One input stream plus two output streams of the demux, bundled for port lists.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are both high;
// once tvalid is high its data/last must hold until that transfer happens.
interface axi_stream_demux_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  select;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tlast;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] stream_output_0;
  logic [DATA_WIDTH-1:0] stream_output_1;
  logic                  m_tlast_0;
  logic                  m_tlast_1;
  logic                  m_tvalid_0;
  logic                  m_tvalid_1;
  logic                  m_tready_0;
  logic                  m_tready_1;

  modport slave (
    input  select, s_tdata, s_tlast, s_tvalid, m_tready_0, m_tready_1,
    output s_tready, stream_output_0, stream_output_1,
           m_tlast_0, m_tlast_1, m_tvalid_0, m_tvalid_1
  );

  modport master (
    output select, s_tdata, s_tlast, s_tvalid, m_tready_0, m_tready_1,
    input  s_tready, stream_output_0, stream_output_1,
           m_tlast_0, m_tlast_1, m_tvalid_0, m_tvalid_1
  );
endinterface

// File: rtl/axi_stream_reg_slice.sv
// Single-entry valid/ready holding register; full throughput when the sink is ready.
module axi_stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Accept a new beat whenever the slot is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_stream_demux.sv
// Packet-aware 1-to-2 AXI-Stream demux: destination is locked for a whole packet,
// with a registered datapath and saturating per-output packet counters.
module axi_stream_demux
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_stream_demux_if.slave    bus,
  output logic [CNT_WIDTH-1:0] pkt_cnt_0,
  output logic [CNT_WIDTH-1:0] pkt_cnt_1,
  output logic                 busy,
  output demux_state_t         state_dbg
);

  localparam int PW = DATA_WIDTH + 2;

  demux_state_t          state, state_nxt;
  logic                  lock_dest, lock_dest_nxt;
  logic                  in_acc;
  logic                  in_dest;
  logic                  slice_in_ready;
  logic                  hold_valid;
  logic                  hold_ready;
  logic [PW-1:0]         hold_payload;
  logic                  hold_dest;
  logic                  hold_last;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  out_last_acc_0;
  logic                  out_last_acc_1;

  assign in_acc  = bus.s_tvalid && bus.s_tready;
  assign in_dest = route_dest(state, bus.select, lock_dest);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_dest <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_dest <= lock_dest_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    lock_dest_nxt = lock_dest;
    case (state)
      IDLE: if (in_acc && !bus.s_tlast) begin
        state_nxt     = PKT;
        lock_dest_nxt = bus.select;
      end
      PKT: if (in_acc && bus.s_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  axi_stream_reg_slice #(.W(PW)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.s_tvalid),
    .in_ready  (slice_in_ready),
    .in_data   ({in_dest, bus.s_tlast, bus.s_tdata}),
    .out_valid (hold_valid),
    .out_ready (hold_ready),
    .out_data  (hold_payload)
  );

  assign {hold_dest, hold_last, hold_data} = hold_payload;
  assign hold_ready = hold_dest ? bus.m_tready_1 : bus.m_tready_0;

  // Handshake outputs are forced low while reset is held, even before the first edge.
  assign bus.s_tready        = rst_n && slice_in_ready;
  assign bus.m_tvalid_0      = rst_n && hold_valid && !hold_dest;
  assign bus.m_tvalid_1      = rst_n && hold_valid && hold_dest;
  assign bus.stream_output_0 = hold_data;
  assign bus.stream_output_1 = hold_data;
  assign bus.m_tlast_0       = hold_last;
  assign bus.m_tlast_1       = hold_last;

  assign out_last_acc_0 = bus.m_tvalid_0 && bus.m_tready_0 && hold_last;
  assign out_last_acc_1 = bus.m_tvalid_1 && bus.m_tready_1 && hold_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_0 <= '0;
    end else if (out_last_acc_0 && (pkt_cnt_0 != '1)) begin
      pkt_cnt_0 <= pkt_cnt_0 + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_1 <= '0;
    end else if (out_last_acc_1 && (pkt_cnt_1 != '1)) begin
      pkt_cnt_1 <= pkt_cnt_1 + CNT_WIDTH'(1);
    end
  end

  assign busy      = (state == PKT);
  assign state_dbg = state;

endmodule

// File: tb/tb_axi_stream_demux.sv
// Bench for axi_stream_demux: directed scenarios plus random traffic, checked against
// a packet-level model; a second instance with 2-bit counters shares the same stimulus.
module tb_axi_stream_demux;
  import axi_stream_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_stream_demux_if #(.DATA_WIDTH(8)) bus ();
  axi_stream_demux_if #(.DATA_WIDTH(8)) sat_bus ();

  logic [15:0]  pkt_cnt_0, pkt_cnt_1;
  logic         busy;
  demux_state_t state_dbg;
  logic [1:0]   sat_cnt_0, sat_cnt_1;
  logic         sat_busy;
  demux_state_t sat_state;

  axi_stream_demux #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pkt_cnt_0 (pkt_cnt_0),
    .pkt_cnt_1 (pkt_cnt_1),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  axi_stream_demux #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sat_bus),
    .pkt_cnt_0 (sat_cnt_0),
    .pkt_cnt_1 (sat_cnt_1),
    .busy      (sat_busy),
    .state_dbg (sat_state)
  );

  assign sat_bus.select     = bus.select;
  assign sat_bus.s_tdata    = bus.s_tdata;
  assign sat_bus.s_tlast    = bus.s_tlast;
  assign sat_bus.s_tvalid   = bus.s_tvalid;
  assign sat_bus.m_tready_0 = bus.m_tready_0;
  assign sat_bus.m_tready_1 = bus.m_tready_1;

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  int   cnt0, cnt1;
  int   out_beats;
  logic in_pkt;
  logic cur_dest;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cap3(input int c);
    return (c > 3) ? 32'd3 : 32'(c);
  endfunction

  task automatic model_clear();
    exp_q0.delete();
    exp_q1.delete();
    cnt0 = 0;
    cnt1 = 0;
    in_pkt = 1'b0;
    cur_dest = 1'b0;
  endtask

  // One clock cycle: drive inputs, check DUT outputs against model, advance model.
  task automatic step(input logic rst, input logic v, input logic sel, input logic [7:0] d,
                      input logic last, input logic r0, input logic r1);
    logic       exp_ready;
    logic       dest;
    logic [8:0] item;
    @(negedge clk);
    rst_n          = rst;
    bus.s_tvalid   = v;
    bus.select     = sel;
    bus.s_tdata    = d;
    bus.s_tlast    = last;
    bus.m_tready_0 = r0;
    bus.m_tready_1 = r1;
    #1;
    exp_ready = rst && ((exp_q0.size() + exp_q1.size() == 0) ||
                        (exp_q0.size() > 0 && r0) || (exp_q1.size() > 0 && r1));
    check("s_tready", 32'(bus.s_tready), 32'(exp_ready));
    check("m_tvalid_0", 32'(bus.m_tvalid_0), 32'(rst && exp_q0.size() > 0));
    check("m_tvalid_1", 32'(bus.m_tvalid_1), 32'(rst && exp_q1.size() > 0));
    if (rst && exp_q0.size() > 0) begin
      check("data_0", 32'(bus.stream_output_0), 32'(exp_q0[0][7:0]));
      check("last_0", 32'(bus.m_tlast_0), 32'(exp_q0[0][8]));
    end
    if (rst && exp_q1.size() > 0) begin
      check("data_1", 32'(bus.stream_output_1), 32'(exp_q1[0][7:0]));
      check("last_1", 32'(bus.m_tlast_1), 32'(exp_q1[0][8]));
    end
    check("pkt_cnt_0", 32'(pkt_cnt_0), 32'(cnt0));
    check("pkt_cnt_1", 32'(pkt_cnt_1), 32'(cnt1));
    check("sat_cnt_0", 32'(sat_cnt_0), cap3(cnt0));
    check("sat_cnt_1", 32'(sat_cnt_1), cap3(cnt1));
    check("busy", 32'(busy), 32'(in_pkt));
    check("state", 32'(state_dbg), 32'(in_pkt ? PKT : IDLE));

    if (!rst) begin
      model_clear();
    end else begin
      if (exp_q0.size() > 0 && r0) begin
        item = exp_q0.pop_front();
        out_beats++;
        if (item[8]) cnt0++;
      end
      if (exp_q1.size() > 0 && r1) begin
        item = exp_q1.pop_front();
        out_beats++;
        if (item[8]) cnt1++;
      end
      if (v && exp_ready) begin
        dest = in_pkt ? cur_dest : sel;
        if (!in_pkt) cur_dest = sel;
        in_pkt = !last;
        if (dest) exp_q1.push_back({last, d});
        else      exp_q0.push_back({last, d});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bus.select = 1'b0;
    bus.s_tdata = '0;
    bus.s_tlast = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.m_tready_0 = 1'b0;
    bus.m_tready_1 = 1'b0;
    out_beats = 0;
    model_clear();

    // reset state
    do_reset();
    check("rst_s_tready", 32'(bus.s_tready), 32'd0);
    check("rst_cnt_0", 32'(pkt_cnt_0), 32'd0);
    idle(1);
    check("post_rst_s_tready", 32'(bus.s_tready), 32'd1);

    // single beat to output 1
    step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("single_data_1", 32'(bus.stream_output_1), 32'hA5);
    check("single_valid_1", 32'(bus.m_tvalid_1), 32'd1);
    check("single_valid_0", 32'(bus.m_tvalid_0), 32'd0);
    idle(1);
    check("single_cnt_1", 32'(pkt_cnt_1), 32'd1);

    // packet lock: select flips after beat 2
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1);
    check("lock_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1);
    check("lock_valid_0", 32'(bus.m_tvalid_0), 32'd1);
    check("lock_data_0", 32'(bus.stream_output_0), 32'h03);
    idle(2);
    check("lock_cnt_0", 32'(pkt_cnt_0), 32'd1);
    check("lock_cnt_1", 32'(pkt_cnt_1), 32'd0);
    check("lock_busy_end", 32'(busy), 32'd0);

    // backpressure on output 0
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1);
      check("bp_s_tready", 32'(bus.s_tready), 32'd0);
      check("bp_data_0", 32'(bus.stream_output_0), 32'h3C);
    end
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("bp_next_data", 32'(bus.stream_output_0), 32'h77);
    idle(1);
    check("bp_cnt_0", 32'(pkt_cnt_0), 32'd2);

    // throughput: 16 alternating single-beat packets
    do_reset();
    base = out_beats;
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'(i % 2), 8'(8'h40 + i), 1'b1, 1'b1, 1'b1);
    idle(2);
    check("tput_beats", 32'(out_beats - base), 32'd16);
    check("tput_cnt_0", 32'(pkt_cnt_0), 32'd8);
    check("tput_cnt_1", 32'(pkt_cnt_1), 32'd8);
    check("tput_sat_0", 32'(sat_cnt_0), 32'd3);

    // reset in the middle of a packet
    do_reset();
    step(1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    do_reset();
    check("mid_rst_valid_1", 32'(bus.m_tvalid_1), 32'd0);
    check("mid_rst_data_1", 32'(bus.stream_output_1), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    check("mid_rst_cnt_1", 32'(pkt_cnt_1), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1);
    idle(2);
    check("mid_rst_new_cnt_0", 32'(pkt_cnt_0), 32'd1);
    check("mid_rst_new_cnt_1", 32'(pkt_cnt_1), 32'd0);

    // saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(i), 1'b1, 1'b1, 1'b1);
    idle(2);
    check("sat_hold_0", 32'(sat_cnt_0), 32'd3);
    check("sat_wide_0", 32'(pkt_cnt_0), 32'd5);

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
